// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : Sequences byte/halfword/word load/store requests into one byte
//            access per cycle on a byte-wide memory port and returns a response.
// Revision : 1.0
// ============================================================================
module mem_access_unit #(
    parameter int word_size = 8,
    parameter int len_log_2 = 16,
    parameter int mem_len   = 65000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [1:0]               req_size,
    input  logic [len_log_2-1:0]     req_addr,
    input  logic [4*word_size-1:0]   req_wdata,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [4*word_size-1:0]   resp_rdata,
    output logic                     resp_err,
    output logic [len_log_2-1:0]     mem_addr,
    output logic [word_size-1:0]     mem_wdata,
    output logic                     mem_we,
    input  logic [word_size-1:0]     mem_rdata
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] XFER = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam int         DW   = 4 * word_size;

    logic [1:0]           state;
    logic                 lat_write;
    logic [1:0]           lat_size;
    logic [len_log_2-1:0] base;
    logic [DW-1:0]        wdata_q;
    logic [DW-1:0]        rdata_q;
    logic                 err_q;
    logic [1:0]           k;

    logic [1:0]           last_k;
    logic [len_log_2-1:0] beat_addr;
    logic                 beat_in_range;
    logic [word_size-1:0] beat_wbyte;

    always_comb begin
        case (lat_size)
            2'd0:    last_k = 2'd0;
            2'd1:    last_k = 2'd1;
            default: last_k = 2'd3;
        endcase
    end

    // Address arithmetic is modulo 2^len_log_2, so a transfer near the top wraps to 0.
    assign beat_addr     = base + len_log_2'(k);
    assign beat_in_range = (64'(beat_addr) < 64'(mem_len));

    always_comb begin
        case (k)
            2'd0:    beat_wbyte = wdata_q[word_size-1:0];
            2'd1:    beat_wbyte = wdata_q[2*word_size-1:word_size];
            2'd2:    beat_wbyte = wdata_q[3*word_size-1:2*word_size];
            default: beat_wbyte = wdata_q[4*word_size-1:3*word_size];
        endcase
    end

    // Write enable is gated by reset so a beat coinciding with reset never lands.
    assign mem_addr   = (state == XFER) ? beat_addr : base;
    assign mem_wdata  = (state == XFER) ? beat_wbyte : wdata_q[word_size-1:0];
    assign mem_we     = (state == XFER) && lat_write && beat_in_range && reset;
    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            lat_write <= 1'b0;
            lat_size  <= 2'd0;
            base      <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            k         <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_write <= req_write;
                        lat_size  <= req_size;
                        base      <= req_addr;
                        wdata_q   <= req_wdata;
                        rdata_q   <= '0;
                        err_q     <= 1'b0;
                        k         <= 2'd0;
                        state     <= XFER;
                    end
                end
                XFER: begin
                    if (!beat_in_range) begin
                        err_q <= 1'b1;
                    end else if (!lat_write) begin
                        for (int b = 0; b < 4; b++) begin
                            if (k == 2'(b)) begin
                                rdata_q[b*word_size +: word_size] <= mem_rdata;
                            end
                        end
                    end
                    if (k == last_k) begin
                        state <= RESP;
                    end else begin
                        k <= k + 2'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Scoreboard bench for mem_access_unit with a byte-array memory.
// Revision : 1.0
// ============================================================================
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [15:0] req_addr = 16'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata;

    logic        fixed_ready = 1'b1;
    logic        rnd_ready = 1'b0;
    logic        rnd_bit = 1'b1;
    assign resp_ready = rnd_ready ? rnd_bit : fixed_ready;

    mem_access_unit #(.word_size(8), .len_log_2(16), .mem_len(65000)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always begin
        @(posedge clk);
        #1;
        rnd_bit = ($urandom_range(0, 3) != 0);
    end

    function automatic logic [7:0] init_byte(input int i);
        return 8'((i * 131 + (i >> 7)) ^ 8'h5A);
    endfunction

    // Physical memory: combinational read, write on the clock edge.
    logic [7:0] mem [0:65535];
    bit mem_init_done = 0;
    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 65536; i++) mem[i] = init_byte(i);
            mem_init_done = 1;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_addr];

    logic [7:0] ref_mem [0:65535];

    typedef struct {
        logic [31:0] rd;
        bit          err;
        int          wes;
        int          n;
        int          acc;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: each beat addresses (base+i) mod 2^16; only addresses below 65000 exist.
    task automatic model(input bit wr, input logic [1:0] sz, input logic [15:0] a,
                         input logic [31:0] wd, output exp_t e);
        int n;
        logic [15:0] ad;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        e.rd = 32'd0; e.err = 0; e.wes = 0; e.n = n; e.acc = 0;
        for (int i = 0; i < n; i++) begin
            ad = a + 16'(i);
            if (int'(ad) < 65000) begin
                if (wr) begin
                    ref_mem[ad] = wd[8*i +: 8];
                    e.wes++;
                end else begin
                    e.rd[8*i +: 8] = ref_mem[ad];
                end
            end else begin
                e.err = 1;
            end
        end
    endtask

    // Monitor: compares every cycle a response is presented.
    logic [31:0] last_rdata = 32'd0;
    logic        last_err = 1'b0;
    int          hs_cyc = 0;
    int          we_cnt = 0;
    bit          prev_v = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            we_cnt = 0;
            prev_v = 0;
        end else begin
            if (mem_we) we_cnt++;
            if (resp_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    e = sb[0];
                    chk("resp_rdata", resp_rdata, e.rd);
                    chk("resp_err", 32'(resp_err), 32'(e.err));
                    chk("req_ready_in_resp", 32'(req_ready), 32'd0);
                    if (!prev_v) chk("resp_latency", 32'(cyc - e.acc), 32'(e.n));
                    if (resp_ready) begin
                        chk("mem_we_count", 32'(we_cnt), 32'(e.wes));
                        last_rdata = resp_rdata;
                        last_err   = resp_err;
                        hs_cyc     = cyc;
                        we_cnt     = 0;
                        void'(sb.pop_front());
                    end
                end
            end
            prev_v = resp_valid;
        end
    end

    int acc_cyc = 0;

    task automatic issue(input bit wr, input logic [1:0] sz, input logic [15:0] a,
                         input logic [31:0] wd, input bit expect_resp);
        bit rdy;
        int guard;
        exp_t e;
        req_write = wr; req_size = sz; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        guard = 0;
        do begin
            @(negedge clk);
            rdy = req_ready;
            @(posedge clk);
            guard++;
        end while (!rdy && guard < 200);
        #1;
        req_valid = 1'b0;
        if (!rdy) begin
            chk("accept_timeout", 32'd0, 32'd1);
        end else begin
            acc_cyc = cyc;
            if (expect_resp) begin
                model(wr, sz, a, wd, e);
                e.acc = cyc;
                sb.push_back(e);
            end
        end
    endtask

    task automatic wait_done();
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 500) begin
            @(posedge clk);
            guard++;
        end
        chk("drain_timeout", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a;
        int prev_acc;
        int bad;
        exp_t dummy;
        for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(i);

        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        @(posedge clk); #1;

        // Word store then word load.
        issue(1, 2'd2, 16'h0100, 32'hDEADBEEF, 1);
        wait_done();
        chk("mem_100", 32'(mem[16'h100]), 32'hEF);
        chk("mem_101", 32'(mem[16'h101]), 32'hBE);
        chk("mem_102", 32'(mem[16'h102]), 32'hAD);
        chk("mem_103", 32'(mem[16'h103]), 32'hDE);
        issue(0, 2'd2, 16'h0100, 32'h0, 1);
        wait_done();
        chk("word_load", last_rdata, 32'hDEADBEEF);
        chk("word_load_err", 32'(last_err), 32'd0);

        // Zero extension and unaligned halfword store.
        issue(1, 2'd0, 16'h0200, 32'hAABBCC80, 1);
        issue(1, 2'd0, 16'h0201, 32'h112233FF, 1);
        issue(0, 2'd0, 16'h0200, 32'h0, 1);
        wait_done();
        chk("byte_load_zext", last_rdata, 32'h00000080);
        issue(0, 2'd1, 16'h0200, 32'h0, 1);
        wait_done();
        chk("half_load_zext", last_rdata, 32'h0000FF80);
        issue(1, 2'd1, 16'h0203, 32'h99881234, 1);
        wait_done();
        chk("mem_203", 32'(mem[16'h203]), 32'h34);
        chk("mem_204", 32'(mem[16'h204]), 32'h12);

        // Out of range.
        issue(1, 2'd2, 16'hFDE6, 32'h01020304, 1);
        wait_done();
        chk("oor_store_err", 32'(last_err), 32'd1);
        chk("oor_no_write_fde8", 32'(mem[16'hFDE8]), 32'(init_byte(16'hFDE8)));
        issue(0, 2'd2, 16'hFFFE, 32'h0, 1);
        wait_done();
        chk("wrap_load", last_rdata, {ref_mem[1], ref_mem[0], 16'h0000});
        chk("wrap_load_err", 32'(last_err), 32'd1);

        // Backpressure: response held, second request waits for the handshake.
        fixed_ready = 1'b0;
        issue(0, 2'd2, 16'h0100, 32'h0, 1);
        fork
            begin
                repeat (10) @(posedge clk);
                #1 fixed_ready = 1'b1;
            end
        join_none
        issue(0, 2'd0, 16'h0102, 32'h0, 1);
        chk("bp_accept_after_hs", 32'(acc_cyc - hs_cyc), 32'd2);
        wait_done();

        // Back-to-back byte loads.
        prev_acc = 0;
        for (int i = 0; i < 6; i++) begin
            issue(0, 2'd0, 16'($urandom_range(0, 65535)), 32'h0, 1);
            if (i > 0) chk("b2b_spacing", 32'(acc_cyc - prev_acc), 32'd3);
            prev_acc = acc_cyc;
        end
        wait_done();

        // Reset during beat 2 of a word store.
        issue(1, 2'd2, 16'h0300, 32'hA1B2C3D4, 0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("postrst_req_ready", 32'(req_ready), 32'd1);
        chk("postrst_resp_valid", 32'(resp_valid), 32'd0);
        chk("postrst_mem_we", 32'(mem_we), 32'd0);
        model(1, 2'd1, 16'h0300, 32'hA1B2C3D4, dummy);
        repeat (6) @(posedge clk);
        #1;
        chk("rst_mem_300", 32'(mem[16'h300]), 32'hD4);
        chk("rst_mem_301", 32'(mem[16'h301]), 32'hC3);
        chk("rst_mem_302", 32'(mem[16'h302]), 32'(init_byte(16'h302)));
        chk("rst_mem_303", 32'(mem[16'h303]), 32'(init_byte(16'h303)));

        // Randomized traffic with random response backpressure.
        rnd_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            a = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 65535))
                                            : 16'($urandom_range(16'hFDE0, 16'hFFFF));
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, $urandom, 1);
        end
        wait_done();
        rnd_ready = 1'b0;

        bad = 0;
        for (int i = 0; i < 65536; i++) if (mem[i] !== ref_mem[i]) bad++;
        chk("mem_sweep_bad_bytes", 32'(bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
